// File: rtl/corr_pkg.sv
// Shared definitions for the windowed correlation scorer: scoring modes,
// FSM encoding and the arithmetic helpers used by the datapath.
package corr_pkg;

    localparam int MODE_SIM = 0;
    localparam int MODE_SAD = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } corr_state_t;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Adds two unsigned values and clamps the result to max_val instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/corr_win_addr_gen.sv
// Raster-order window address generator: x/y counters over WIN_W x WIN_H,
// latched start offset for the SRAM side, and a last-address flag.
module corr_win_addr_gen
    import corr_pkg::*;
#(
    parameter int COORD_W = 13,
    parameter int WIN_W   = 64,
    parameter int WIN_H   = 48
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_xstart,
    input  logic [COORD_W-1:0] i_ystart,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [COORD_W-1:0] o_x_sram,
    output logic [COORD_W-1:0] o_y_sram,
    output logic [COORD_W-1:0] o_x_base,
    output logic [COORD_W-1:0] o_y_base,
    output logic               o_last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(WIN_H - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_xbase;
    logic [COORD_W-1:0] r_ybase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_xbase <= '0;
            r_ybase <= '0;
        end else if (i_load) begin
            r_x     <= '0;
            r_y     <= '0;
            r_xbase <= i_xstart;
            r_ybase <= i_ystart;
        end else if (i_step) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_x_sram = r_xbase + r_x;
    assign o_y_sram = r_ybase + r_y;
    assign o_x_base = r_xbase;
    assign o_y_base = r_ybase;
    assign o_last   = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/corr_window_scorer.sv
// Correlation scorer: scans a window of the stored frame against the template,
// accumulates a saturating similarity/SAD score and tracks the best run.
module corr_window_scorer
    import corr_pkg::*;
#(
    parameter int PIX_W   = 10,
    parameter int COORD_W = 13,
    parameter int WIN_W   = 64,
    parameter int WIN_H   = 48,
    parameter int RD_LAT  = 1,
    parameter int SCORE_W = 32,
    parameter int MODE    = 0
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic               iClearBest,
    input  logic [COORD_W-1:0] iXstart,
    input  logic [COORD_W-1:0] iYstart,
    output logic               oRdEn,
    output logic [COORD_W-1:0] oX_sram,
    output logic [COORD_W-1:0] oY_sram,
    output logic [COORD_W-1:0] oX_search,
    output logic [COORD_W-1:0] oY_search,
    input  logic [PIX_W-1:0]   iPixSram,
    input  logic [PIX_W-1:0]   iPixSearch,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCORE_W-1:0] oScore,
    output logic               oBestValid,
    output logic [SCORE_W-1:0] oBestScore,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY
);

    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [63:0] ACC_MAX = (SCORE_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                      : ((64'd1 << SCORE_W) - 64'd1);

    corr_state_t        r_state;
    logic               r_busy;
    logic               r_rd_en;
    logic               r_done;
    logic [2:0]         r_drain_cnt;
    logic [SCORE_W-1:0] r_acc;
    logic [SCORE_W-1:0] r_score;
    logic               r_best_valid;
    logic [SCORE_W-1:0] r_best_score;
    logic [COORD_W-1:0] r_best_x;
    logic [COORD_W-1:0] r_best_y;

    logic               w_start;
    logic               w_flush;
    logic               w_step;
    logic               w_last;
    logic               w_valid;
    logic               w_better;
    logic [COORD_W-1:0] w_xbase;
    logic [COORD_W-1:0] w_ybase;
    logic [PIX_W-1:0]   w_diff;
    logic [PIX_W-1:0]   w_term;
    logic [SCORE_W-1:0] w_acc_sum;
    logic [SCORE_W-1:0] w_acc_upd;

    assign w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && iStart;
    assign w_flush = iAbort && ((r_state == ST_SCAN) || (r_state == ST_DRAIN));
    assign w_step  = (r_state == ST_SCAN) && !iAbort && !w_last;

    corr_win_addr_gen #(
        .COORD_W (COORD_W),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H)
    ) u_addr_gen (
        .i_clk    (iCLK),
        .i_rst_n  (iRST_N),
        .i_load   (w_start),
        .i_step   (w_step),
        .i_xstart (iXstart),
        .i_ystart (iYstart),
        .o_x      (oX_search),
        .o_y      (oY_search),
        .o_x_sram (oX_sram),
        .o_y_sram (oY_sram),
        .o_x_base (w_xbase),
        .o_y_base (w_ybase),
        .o_last   (w_last)
    );

    // The valid pipeline mirrors the reader latency so only real pixels are summed.
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign w_valid = r_rd_en;
        end else begin : g_lat
            logic [RD_LAT-1:0] r_vld;
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    r_vld <= '0;
                end else if (w_flush) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= RD_LAT'({r_vld, r_rd_en});
                end
            end
            assign w_valid = r_vld[RD_LAT-1];
        end
    endgenerate

    assign w_diff    = PIX_W'(abs_diff(32'(iPixSram), 32'(iPixSearch)));
    assign w_term    = (MODE == MODE_SAD) ? w_diff : (PIX_MAX - w_diff);
    assign w_acc_sum = SCORE_W'(sat_add(64'(r_acc), 64'(w_term), ACC_MAX));
    assign w_acc_upd = w_valid ? w_acc_sum : r_acc;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= '0;
            r_acc       <= '0;
            r_score     <= '0;
        end else begin
            r_done <= 1'b0;
            r_acc  <= w_acc_upd;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (w_start) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_acc   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (iAbort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_rd_en <= 1'b0;
                    end else if (w_last) begin
                        r_rd_en <= 1'b0;
                        if (RD_LAT == 0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_score <= w_acc_upd;
                        end else begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= 3'(RD_LAT - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (iAbort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == 3'd0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_score <= w_acc_upd;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A clear coinciding with DONE is folded in first, so the fresh result is kept.
    assign w_better = (MODE == MODE_SAD) ? (r_score < r_best_score) : (r_score > r_best_score);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_best_valid <= 1'b0;
            r_best_score <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
        end else if ((r_state == ST_DONE) && (!r_best_valid || iClearBest || w_better)) begin
            r_best_valid <= 1'b1;
            r_best_score <= r_score;
            r_best_x     <= w_xbase;
            r_best_y     <= w_ybase;
        end else if (iClearBest) begin
            r_best_valid <= 1'b0;
        end
    end

    assign oRdEn      = r_rd_en;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oScore     = r_score;
    assign oBestValid = r_best_valid;
    assign oBestScore = r_best_score;
    assign oBestX     = r_best_x;
    assign oBestY     = r_best_y;

endmodule

// File: tb/tb_corr_window_scorer.sv
// Scoreboard bench: DUT A is a 4x2 similarity scorer with two-cycle readers,
// DUT B a 4x2 SAD scorer with zero-latency readers and a 12-bit score.
module tb_corr_window_scorer;

    localparam int PW = 10;
    localparam int CW = 13;
    localparam int WW = 4;
    localparam int WH = 2;
    localparam int N  = WW * WH;

    typedef struct {
        longint score;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    logic [CW-1:0] xs = '0, ys = '0;

    // DUT A signals
    logic          start_a = 1'b0, abort_a = 1'b0, clr_a = 1'b0;
    logic          rden_a, busy_a, done_a, bv_a;
    logic [CW-1:0] xsr_a, ysr_a, xse_a, yse_a, bx_a, by_a;
    logic [PW-1:0] pixs_a, pixt_a;
    logic [31:0]   score_a, bs_a;

    // DUT B signals
    logic          start_b = 1'b0;
    logic          rden_b, busy_b, done_b, bv_b;
    logic [CW-1:0] xsr_b, ysr_b, xse_b, yse_b, bx_b, by_b;
    logic [PW-1:0] pixs_b, pixt_b;
    logic [11:0]   score_b, bs_b;

    corr_window_scorer #(
        .PIX_W(PW), .COORD_W(CW), .WIN_W(WW), .WIN_H(WH),
        .RD_LAT(2), .SCORE_W(32), .MODE(0)
    ) u_dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start_a), .iAbort(abort_a),
        .iClearBest(clr_a), .iXstart(xs), .iYstart(ys), .oRdEn(rden_a),
        .oX_sram(xsr_a), .oY_sram(ysr_a), .oX_search(xse_a), .oY_search(yse_a),
        .iPixSram(pixs_a), .iPixSearch(pixt_a), .oBusy(busy_a), .oDone(done_a),
        .oScore(score_a), .oBestValid(bv_a), .oBestScore(bs_a),
        .oBestX(bx_a), .oBestY(by_a)
    );

    corr_window_scorer #(
        .PIX_W(PW), .COORD_W(CW), .WIN_W(WW), .WIN_H(WH),
        .RD_LAT(0), .SCORE_W(12), .MODE(1)
    ) u_dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start_b), .iAbort(1'b0),
        .iClearBest(1'b0), .iXstart(xs), .iYstart(ys), .oRdEn(rden_b),
        .oX_sram(xsr_b), .oY_sram(ysr_b), .oX_search(xse_b), .oY_search(yse_b),
        .iPixSram(pixs_b), .iPixSearch(pixt_b), .oBusy(busy_b), .oDone(done_b),
        .oScore(score_b), .oBestValid(bv_b), .oBestScore(bs_b),
        .oBestX(bx_b), .oBestY(by_b)
    );

    // Reader models: address-dependent SRAM pixel, constant template pixel,
    // and a junk value whenever no read is in flight.
    logic [PW-1:0] a_base = '0, a_step = '0, a_tmpl = '0;
    logic [PW-1:0] b_base = '0, b_tmpl = '0;
    logic [1:0]    pen = '0;
    logic [PW-1:0] pv0 = '0, pv1 = '0;

    always @(posedge clk) begin
        pen <= {pen[0], rden_a};
        pv0 <= a_base + PW'(int'(yse_a) * WW + int'(xse_a)) * a_step;
        pv1 <= pv0;
    end
    assign pixs_a = pen[1] ? pv1 : 10'd777;
    assign pixt_a = pen[1] ? a_tmpl : 10'd0;
    assign pixs_b = rden_b ? b_base : 10'd777;
    assign pixt_b = rden_b ? b_tmpl : 10'd0;

    function automatic longint exp_score(input int mode, input int sw,
                                         input logic [PW-1:0] base, input logic [PW-1:0] step,
                                         input logic [PW-1:0] tmpl);
        longint acc = 0;
        longint mx = (longint'(1) << sw) - 1;
        logic [PW-1:0] s;
        int d;
        for (int k = 0; k < N; k++) begin
            s = base + PW'(k) * step;
            d = (s > tmpl) ? int'(s) - int'(tmpl) : int'(tmpl) - int'(s);
            acc += (mode == 1) ? d : 1023 - d;
        end
        return (acc > mx) ? mx : acc;
    endfunction

    exp_t qa[$];
    exp_t qb[$];
    int   ai = 0;
    int   a_xb = 0, a_yb = 0;

    // Best-match reference models
    bit     ma_bv = 0, mb_bv = 0;
    longint ma_bs = 0, mb_bs = 0, a_last = 0;
    int     ma_bx = 0, ma_by = 0, mb_bx = 0, mb_by = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (rden_a) begin
                chk("a_x_sram", xsr_a, a_xb + ai % WW);
                chk("a_y_sram", ysr_a, a_yb + ai / WW);
                ai++;
            end
            if (done_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", done_a, 0);
                end else begin
                    e = qa.pop_front();
                    $display("A done: score %0d (exp %0d) at cycle %0d", score_a, e.score, cyc);
                    chk("a_score", score_a, e.score);
                    chk("a_done_cycle", cyc, e.cyc);
                    chk("a_addr_count", ai, N);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && done_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", done_b, 0);
            end else begin
                e = qb.pop_front();
                $display("B done: score %0d (exp %0d) at cycle %0d", score_b, e.score, cyc);
                chk("b_score", score_b, e.score);
                chk("b_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_done_a(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_a) got = 1;
        end
        if (!got) chk("a_done_timeout", done_a, 1);
    endtask

    task automatic wait_done_b(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_b) got = 1;
        end
        if (!got) chk("b_done_timeout", done_b, 1);
    endtask

    task automatic best_model_a(input longint sc, input int x, input int y, input bit clr);
        if (clr || !ma_bv || sc > ma_bs) begin
            ma_bv = 1; ma_bs = sc; ma_bx = x; ma_by = y;
        end
        a_last = sc;
    endtask

    task automatic check_best_a();
        chk("a_best_valid", bv_a, ma_bv);
        chk("a_best_score", bs_a, ma_bs);
        chk("a_best_x", bx_a, ma_bx);
        chk("a_best_y", by_a, ma_by);
    endtask

    task automatic run_a(input int x, input int y, input logic [PW-1:0] base,
                         input logic [PW-1:0] step, input logic [PW-1:0] tmpl, input bit clr_at_done);
        exp_t e;
        a_base = base; a_step = step; a_tmpl = tmpl;
        @(posedge clk); #1;
        xs = CW'(x); ys = CW'(y); start_a = 1'b1;
        ai = 0; a_xb = x; a_yb = y;
        e.score = exp_score(0, 32, base, step, tmpl);
        e.cyc = cyc + N + 2 + 1;
        qa.push_back(e);
        @(posedge clk); #1;
        start_a = 1'b0; xs = CW'(x + 7); ys = CW'(y + 3);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a(40);
        if (clr_at_done) clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        best_model_a(e.score, x, y, clr_at_done);
        check_best_a();
    endtask

    task automatic run_b(input int x, input int y, input logic [PW-1:0] base, input logic [PW-1:0] tmpl);
        exp_t e;
        b_base = base; b_tmpl = tmpl;
        @(posedge clk); #1;
        xs = CW'(x); ys = CW'(y); start_b = 1'b1;
        e.score = exp_score(1, 12, base, 10'd0, tmpl);
        e.cyc = cyc + N + 0 + 1;
        qb.push_back(e);
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_done_b(40);
        @(posedge clk); #1;
        if (!mb_bv || e.score < mb_bs) begin
            mb_bv = 1; mb_bs = e.score; mb_bx = x; mb_by = y;
        end
        chk("b_best_valid", bv_b, mb_bv);
        chk("b_best_score", bs_b, mb_bs);
        chk("b_best_x", bx_b, mb_bx);
        chk("b_best_y", by_b, mb_by);
    endtask

    task automatic pulse_clear_a();
        @(posedge clk); #1;
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        ma_bv = 0;
        chk("a_clear_best_valid", bv_a, 0);
    endtask

    initial begin : watchdog
        #(20 * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   s;
        #15;
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_done", done_a, 0);
        chk("rst_a_rden", rden_a, 0);
        chk("rst_a_score", score_a, 0);
        chk("rst_a_best_valid", bv_a, 0);
        chk("rst_a_x_sram", xsr_a, 0);
        chk("rst_b_score", score_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Similarity, identical pixels; then an address-dependent pattern
        run_a(10, 20, 10'd500, 10'd0, 10'd500, 0);
        run_a(1, 1, 10'd100, 10'd37, 10'd300, 0);

        // Best tracking, tie handling and clears
        pulse_clear_a();
        run_a(0, 0, 10'd500, 10'd0, 10'd352, 0);
        run_a(5, 0, 10'd500, 10'd0, 10'd500, 0);
        run_a(9, 3, 10'd500, 10'd0, 10'd500, 0);
        pulse_clear_a();
        run_a(2, 2, 10'd1011, 10'd0, 10'd0, 0);
        run_a(3, 3, 10'd1023, 10'd0, 10'd0, 1);

        // Abort in the third SCAN cycle
        @(posedge clk); #1;
        xs = 13'd4; ys = 13'd4; start_a = 1'b1; ai = 0; a_xb = 4; a_yb = 4;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_rden", rden_a, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_score_held", score_a, a_last);
        check_best_a();
        run_a(6, 6, 10'd500, 10'd0, 10'd500, 0);

        // Back-to-back: start held through DONE with new coordinates
        a_base = 10'd200; a_step = 10'd0; a_tmpl = 10'd210;
        @(posedge clk); #1;
        xs = 13'd11; ys = 13'd12; start_a = 1'b1; ai = 0; a_xb = 11; a_yb = 12;
        e.score = exp_score(0, 32, 10'd200, 10'd0, 10'd210);
        e.cyc = cyc + N + 3;
        qa.push_back(e);
        @(posedge clk); #1;
        xs = 13'd30; ys = 13'd31;
        wait_done_a(40);
        @(posedge clk); #1;
        start_a = 1'b0; ai = 0; a_xb = 30; a_yb = 31;
        e.cyc = cyc - 1 + N + 3;
        qa.push_back(e);
        chk("b2b_busy", busy_a, 1);
        chk("b2b_rden", rden_a, 1);
        best_model_a(e.score, 11, 12, 0);
        wait_done_a(40);
        @(posedge clk); #1;
        best_model_a(e.score, 30, 31, 0);
        check_best_a();

        // Asynchronous reset during DRAIN
        @(posedge clk); #1;
        xs = 13'd8; ys = 13'd8; start_a = 1'b1; ai = 0; a_xb = 8; a_yb = 8;
        s = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("drain_cycle", cyc, s + N + 1);
        chk("drain_busy", busy_a, 1);
        chk("drain_rden", rden_a, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_score", score_a, 0);
        chk("arst_best_valid", bv_a, 0);
        chk("arst_best_score", bs_a, 0);
        chk("arst_x_sram", xsr_a, 0);
        chk("arst_y_sram", ysr_a, 0);
        chk("arst_x_search", xse_a, 0);
        ma_bv = 0; ma_bs = 0; ma_bx = 0; ma_by = 0; a_last = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_no_done_score", score_a, 0);
        run_a(7, 1, 10'd300, 10'd0, 10'd300, 0);

        // SAD, zero read latency, 12-bit saturating score
        run_b(1, 2, 10'd100, 10'd40);
        run_b(3, 4, 10'd40, 10'd100);
        run_b(5, 6, 10'd1023, 10'd0);

        repeat (3) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
